// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the main data memory port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE / ISSUE / RESP)
//   - arb_owner_t : which requester currently holds the port
//   - ADDR_W_DEF / DATA_W_DEF : default byte-address and data widths
//   - addr_misaligned() : word-alignment test on a byte address
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    // A word access is aligned only when the two byte-offset bits are zero.
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single port of the 4096-byte main data memory
// between instruction fetch (IF, read-only) and the memory stage (MEM,
// read/write). A three-state FSM (IDLE -> ISSUE -> RESP) drives registered RAM
// commands; MEM has priority, and the requester just acked in RESP cannot win
// the next arbitration, so contention alternates MEM, IF, MEM, ...
//
// Optional build macro: MEM_ARB_ALIGN_CHK_EN
//   defined   : word-misaligned addresses are not sent to the RAM (ram_en stays
//               0); the access still takes ISSUE/RESP and is acked with err=1
//               and rdata=0.
//   undefined : err is tied 0 and every address is forwarded unchanged.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   if_req/if_addr                 IF read request (held until if_ack)
//   if_ack/if_rdata/if_err         IF completion pulse, read data, misalign flag
//   if_stall                       if_req & ~if_ack
//   mem_req/mem_we/mem_addr/mem_wdata  MEM request (held until mem_ack)
//   mem_ack/mem_rdata/mem_err      MEM completion pulse, read data, misalign flag
//   mem_stall                      mem_req & ~mem_ack
//   ram_en/ram_we/ram_addr/ram_wdata   registered RAM command
//   ram_rdata                      RAM read data, valid the cycle after ram_en
//   busy                           FSM not in IDLE
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    output logic              if_stall,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              mem_stall,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              busy
);

`ifdef MEM_ARB_ALIGN_CHK_EN
    localparam logic ALIGN_CHK = 1'b1;
`else
    localparam logic ALIGN_CHK = 1'b0;
`endif

    arb_state_t        r_state;
    arb_owner_t        r_owner;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_misalign;

    arb_state_t        w_state_nxt;
    arb_owner_t        w_owner_nxt;
    logic              w_ram_en_nxt;
    logic              w_ram_we_nxt;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic [DATA_W-1:0] w_ram_wdata_nxt;
    logic              w_misalign_nxt;
    logic              w_load_mem;
    logic              w_load_if;
    logic              w_mem_mis;
    logic              w_if_mis;
    logic              w_resp;

    // Misalignment is only ever flagged when the check is built in.
    assign w_mem_mis = ALIGN_CHK & addr_misaligned(mem_addr[1:0]);
    assign w_if_mis  = ALIGN_CHK & addr_misaligned(if_addr[1:0]);

    // State and command registers; reset drops ram_en at once so an
    // in-flight write never reaches the RAM edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ram_en    <= w_ram_en_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_misalign  <= w_misalign_nxt;
        end
    end

    // Next-state arbitration and command load.
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_ram_en_nxt    = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_misalign_nxt  = r_misalign;
        w_load_mem      = 1'b0;
        w_load_if       = 1'b0;

        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_load_mem = 1'b1;
                end else if (if_req) begin
                    w_load_if = 1'b1;
                end
            end
            ISSUE: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                // The requester acked this cycle sits out; only the other may load.
                w_state_nxt = IDLE;
                if (r_owner == OWN_IF) begin
                    w_load_mem = mem_req;
                end else begin
                    w_load_if = if_req;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load_mem) begin
            w_state_nxt     = ISSUE;
            w_owner_nxt     = OWN_MEM;
            w_ram_en_nxt    = ~w_mem_mis;
            w_ram_we_nxt    = mem_we & ~w_mem_mis;
            w_ram_addr_nxt  = mem_addr;
            w_ram_wdata_nxt = mem_wdata;
            w_misalign_nxt  = w_mem_mis;
        end else if (w_load_if) begin
            w_state_nxt     = ISSUE;
            w_owner_nxt     = OWN_IF;
            w_ram_en_nxt    = ~w_if_mis;
            w_ram_we_nxt    = 1'b0;
            w_ram_addr_nxt  = if_addr;
            w_misalign_nxt  = w_if_mis;
        end
    end

    // Response decode: acks come straight from state and owner.
    assign w_resp    = (r_state == RESP);
    assign if_ack    = w_resp & (r_owner == OWN_IF);
    assign mem_ack   = w_resp & (r_owner == OWN_MEM);
    assign if_err    = if_ack & r_misalign;
    assign mem_err   = mem_ack & r_misalign;
    assign if_rdata  = r_misalign ? '0 : ram_rdata;
    assign mem_rdata = r_misalign ? '0 : ram_rdata;
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a
// byte-wide behavioural RAM (little-endian words, one-cycle read latency).
// Honours MEM_ARB_ALIGN_CHK_EN to select the misaligned-access expectations.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ALIGN_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack, if_err, if_stall;
    logic [11:0] if_addr;
    logic [31:0] if_rdata;
    logic        mem_req, mem_we, mem_ack, mem_err, mem_stall;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        ram_en, ram_we, busy;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int checks   = 0;
    int failures = 0;
    int proto_err = 0;

    logic [7:0] ram [0:4095];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .mem_stall (mem_stall),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // Behavioural RAM.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram[ram_addr]         <= ram_wdata[7:0];
                ram[ram_addr + 12'd1] <= ram_wdata[15:8];
                ram[ram_addr + 12'd2] <= ram_wdata[23:16];
                ram[ram_addr + 12'd3] <= ram_wdata[31:24];
            end else begin
                ram_rdata <= {ram[ram_addr + 12'd3], ram[ram_addr + 12'd2],
                              ram[ram_addr + 12'd1], ram[ram_addr]};
            end
        end
    end

    // Requester-side contract: a pending request must not drop before its ack.
    logic prev_if_pend = 1'b0, prev_mem_pend = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            prev_if_pend  = 1'b0;
            prev_mem_pend = 1'b0;
        end else begin
            if (prev_if_pend && !if_req) begin
                proto_err++;
                $display("FAIL proto_if_req_dropped t=%0t", $time);
            end
            if (prev_mem_pend && !mem_req) begin
                proto_err++;
                $display("FAIL proto_mem_req_dropped t=%0t", $time);
            end
            prev_if_pend  = if_req && !if_ack;
            prev_mem_pend = mem_req && !mem_ack;
        end
    end

    function automatic logic [31:0] word_at(input logic [11:0] a);
        return {ram[a + 12'd3], ram[a + 12'd2], ram[a + 12'd1], ram[a]};
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) ram[a + 12'(i)] = d[8*i +: 8];
    endtask

    // One cycle boundary: inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            checks++;
            if ({ram_en, ram_we, ram_addr, if_ack, mem_ack, busy, if_err, mem_err} !== 19'h0) begin
                failures++;
                $display("FAIL reset_hold: en=%b we=%b addr=%h if_ack=%b mem_ack=%b busy=%b want all 0",
                         ram_en, ram_we, ram_addr, if_ack, mem_ack, busy);
            end
        end
        cyc(); rst = 1'b0;
        // Mid-run reset: start an IF read, hit reset during ISSUE.
        cyc(); if_req = 1'b1; if_addr = 12'h010;
        cyc(); settle();
        checks++;
        if (ram_en !== 1'b1) begin
            failures++; $display("FAIL reset_midrun_issue: ram_en=%b want 1", ram_en);
        end
        #2 rst = 1'b1; if_req = 1'b0;
        #1;
        checks++;
        if ({ram_en, ram_addr, if_ack, mem_ack, busy} !== 16'h0) begin
            failures++;
            $display("FAIL reset_midrun_async: en=%b addr=%h if_ack=%b mem_ack=%b busy=%b want 0",
                     ram_en, ram_addr, if_ack, mem_ack, busy);
        end
        cyc(); settle();
        checks++;
        if ({ram_en, ram_addr, if_ack, mem_ack, busy} !== 16'h0) begin
            failures++; $display("FAIL reset_midrun_held: en=%b busy=%b want 0", ram_en, busy);
        end
        cyc(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            checks++;
            if ({if_ack, mem_ack, busy, ram_en} !== 4'h0) begin
                failures++;
                $display("FAIL reset_after_release: if_ack=%b mem_ack=%b busy=%b en=%b want 0",
                         if_ack, mem_ack, busy, ram_en);
            end
        end
    endtask

    task automatic test_if_read();
        cyc(); if_req = 1'b1; if_addr = 12'h010; settle();
        checks++;
        if ({if_stall, busy} !== 2'b10) begin
            failures++; $display("FAIL ifrd_c0: stall=%b busy=%b want 1 0", if_stall, busy);
        end
        cyc(); settle();
        checks++;
        if ({ram_en, ram_we, ram_addr, if_ack} !== {1'b1, 1'b0, 12'h010, 1'b0}) begin
            failures++;
            $display("FAIL ifrd_c1: en=%b we=%b addr=%h ack=%b want 1 0 010 0", ram_en, ram_we, ram_addr, if_ack);
        end
        cyc(); settle();
        checks++;
        if ({if_ack, if_err, if_stall, mem_ack} !== 4'b1000 || if_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL ifrd_c2: ack=%b err=%b stall=%b rdata=%h want 1 0 0 deadbeef",
                     if_ack, if_err, if_stall, if_rdata);
        end
        cyc(); if_req = 1'b0; settle();
        checks++;
        if ({busy, ram_en, if_ack} !== 3'b000) begin
            failures++; $display("FAIL ifrd_c3: busy=%b en=%b ack=%b want 0", busy, ram_en, if_ack);
        end
    endtask

    task automatic test_contention();
        cyc();
        if_req = 1'b1; if_addr = 12'h020;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'h100; mem_wdata = 32'h12345678;
        settle();
        checks++;
        if ({if_stall, mem_stall} !== 2'b11) begin
            failures++; $display("FAIL cont_c0: if_stall=%b mem_stall=%b want 1 1", if_stall, mem_stall);
        end
        cyc(); settle();
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 12'h100, 32'h12345678}) begin
            failures++;
            $display("FAIL cont_c1: en=%b we=%b addr=%h wdata=%h want 1 1 100 12345678",
                     ram_en, ram_we, ram_addr, ram_wdata);
        end
        cyc(); settle();
        checks++;
        if ({mem_ack, mem_err, if_ack, ram_en} !== 4'b1000) begin
            failures++;
            $display("FAIL cont_c2: mem_ack=%b mem_err=%b if_ack=%b en=%b want 1 0 0 0",
                     mem_ack, mem_err, if_ack, ram_en);
        end
        cyc(); mem_req = 1'b0; mem_we = 1'b0; settle();
        checks++;
        if ({ram_en, ram_we, ram_addr, if_stall} !== {1'b1, 1'b0, 12'h020, 1'b1}) begin
            failures++;
            $display("FAIL cont_c3: en=%b we=%b addr=%h if_stall=%b want 1 0 020 1",
                     ram_en, ram_we, ram_addr, if_stall);
        end
        cyc(); settle();
        checks++;
        if ({if_ack, mem_ack} !== 2'b10 || if_rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL cont_c4: if_ack=%b mem_ack=%b rdata=%h want 1 0 cafef00d", if_ack, mem_ack, if_rdata);
        end
        // Read back the written word through the MEM port.
        cyc(); if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h100;
        cyc(); cyc(); settle();
        checks++;
        if (mem_ack !== 1'b1 || mem_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL cont_readback: ack=%b rdata=%h want 1 12345678", mem_ack, mem_rdata);
        end
        cyc(); mem_req = 1'b0;
    endtask

    task automatic test_alternation();
        logic exp_m, exp_i;
        int run = 0, max_run = 0;
        mem_we = 1'b0; mem_addr = 12'h100; if_addr = 12'h010;
        for (int k = 0; k < 21; k++) begin
            cyc();
            if (k == 0) begin if_req = 1'b1; mem_req = 1'b1; end
            settle();
            exp_m = (k % 4 == 2);
            exp_i = (k >= 4) && (k % 4 == 0);
            checks++;
            if ({mem_ack, if_ack} !== {exp_m, exp_i}) begin
                failures++;
                $display("FAIL alt_c%0d: mem_ack=%b if_ack=%b want %b %b", k, mem_ack, if_ack, exp_m, exp_i);
            end
            run = if_stall ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        checks++;
        if (max_run > 4) begin
            failures++; $display("FAIL alt_if_stall_run: longest=%0d want <=4", max_run);
        end
        cyc(); if_req = 1'b0; settle();
        checks++;
        if ({mem_ack, ram_en, ram_addr} !== {1'b0, 1'b1, 12'h100}) begin
            failures++; $display("FAIL alt_tail_issue: ack=%b en=%b addr=%h want 0 1 100", mem_ack, ram_en, ram_addr);
        end
        cyc(); settle();
        checks++;
        if (mem_ack !== 1'b1 || mem_rdata !== 32'h12345678) begin
            failures++; $display("FAIL alt_tail_ack: ack=%b rdata=%h want 1 12345678", mem_ack, mem_rdata);
        end
        cyc(); mem_req = 1'b0; settle();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL alt_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_misaligned();
        preload(12'h104, 32'h0BADF00D);
        cyc(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'h102; mem_wdata = 32'hA5A5A5A5;
        cyc(); settle();
        checks++;
        if (CHK) begin
            if ({ram_en, busy} !== 2'b01) begin
                failures++; $display("FAIL mis_wr_c1: en=%b busy=%b want 0 1", ram_en, busy);
            end
        end else if ({ram_en, ram_addr} !== {1'b1, 12'h102}) begin
            failures++; $display("FAIL mis_wr_c1: en=%b addr=%h want 1 102", ram_en, ram_addr);
        end
        cyc(); settle();
        checks++;
        if ({mem_ack, mem_err, ram_en} !== {1'b1, CHK, 1'b0}) begin
            failures++; $display("FAIL mis_wr_c2: ack=%b err=%b en=%b want 1 %b 0", mem_ack, mem_err, ram_en, CHK);
        end
        cyc(); mem_req = 1'b0; mem_we = 1'b0; settle();
        checks++;
        if (word_at(12'h100) !== (CHK ? 32'h12345678 : 32'hA5A55678) ||
            word_at(12'h104) !== (CHK ? 32'h0BADF00D : 32'h0BADA5A5)) begin
            failures++;
            $display("FAIL mis_wr_mem: w100=%h w104=%h chk=%b", word_at(12'h100), word_at(12'h104), CHK);
        end
        // Misaligned IF read at 0x011: bytes 11..14 = BE AD DE 00.
        cyc(); if_req = 1'b1; if_addr = 12'h011;
        cyc(); cyc(); settle();
        checks++;
        if ({if_ack, if_err} !== {1'b1, CHK} || if_rdata !== (CHK ? 32'h0 : 32'h00DEADBE)) begin
            failures++;
            $display("FAIL mis_rd: ack=%b err=%b rdata=%h chk=%b", if_ack, if_err, if_rdata, CHK);
        end
        cyc(); if_req = 1'b0;
    endtask

    task automatic test_reset_during_issue();
        preload(12'h200, 32'h55AA55AA);
        cyc(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'h200; mem_wdata = 32'hFFFFFFFF;
        cyc(); settle();
        checks++;
        if ({ram_en, ram_we} !== 2'b11) begin
            failures++; $display("FAIL rst_issue_pre: en=%b we=%b want 1 1", ram_en, ram_we);
        end
        #2 rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        #1;
        checks++;
        if ({ram_en, ram_we, mem_ack} !== 3'b000) begin
            failures++; $display("FAIL rst_issue_drop: en=%b we=%b ack=%b want 0", ram_en, ram_we, mem_ack);
        end
        cyc(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); settle();
            checks++;
            if ({mem_ack, busy} !== 2'b00) begin
                failures++; $display("FAIL rst_issue_noack_%0d: ack=%b busy=%b want 0 0", i, mem_ack, busy);
            end
        end
        checks++;
        if (word_at(12'h200) !== 32'h55AA55AA) begin
            failures++; $display("FAIL rst_issue_mem: w200=%h want 55aa55aa", word_at(12'h200));
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        preload(12'h010, 32'hDEADBEEF);
        preload(12'h020, 32'hCAFEF00D);
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

        test_reset();
        test_if_read();
        test_contention();
        test_alternation();
        test_misaligned();
        test_reset_during_issue();

        checks++;
        if (proto_err != 0) begin
            failures++; $display("FAIL proto_total: violations=%0d want 0", proto_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single port of the 4096-byte main data memory between instruction fetch (IF, read-only) and the memory stage (MEM, read/write). It uses a three-state FSM with a req/ack handshake per requester and registered RAM command outputs. It produces the stall signals the pipeline hazard controller uses to freeze IF or MEM while they wait for the port.

## Interface
- ADDR_W, 12, byte-address width (4096 bytes)
- DATA_W, 32, data word width
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  IF access request; held until if_ack
- if_addr  input  ADDR_W  IF byte address
- if_ack  output  1  one-cycle completion pulse to IF
- if_rdata  output  DATA_W  IF read data; valid while if_ack=1
- if_err  output  1  IF misaligned-access flag; valid while if_ack=1
- if_stall  output  1  if_req & ~if_ack
- mem_req  input  1  MEM access request; held until mem_ack
- mem_we  input  1  1=write, 0=read
- mem_addr  input  ADDR_W  MEM byte address
- mem_wdata  input  DATA_W  MEM write data
- mem_ack  output  1  one-cycle completion pulse to MEM
- mem_rdata  output  DATA_W  MEM read data; valid while mem_ack=1 and mem_we=0
- mem_err  output  1  MEM misaligned-access flag; valid while mem_ack=1
- mem_stall  output  1  mem_req & ~mem_ack
- ram_en, ram_we  output  1 each  registered RAM command
- ram_addr  output  ADDR_W  registered RAM byte address (RAM assembles little-endian bytes addr..addr+3)
- ram_wdata  output  DATA_W  registered RAM write data
- ram_rdata  input  DATA_W  RAM read data; valid the cycle after ram_en
- busy  output  1  state != IDLE

## Operation
- FSM states are IDLE, ISSUE and RESP. A registered owner bit records which requester holds the port (IF or MEM).
- IDLE:
  - If mem_req: owner=MEM, load ram_* from the MEM inputs, go to ISSUE.
  - Else if if_req: owner=IF, ram_we=0, go to ISSUE.
  - Else stay in IDLE.
- ISSUE: ram_en=1 for exactly one cycle; always go to RESP. A write commits at the end of this cycle.
- RESP:
  - ram_en=0 and ram_we=0.
  - The owner's ack=1. The owner's rdata is ram_rdata passed through combinationally; rdata is undefined for writes.
  - The requester acked in this cycle is ineligible for arbitration. If the other requester's req=1, load it and go to ISSUE; otherwise go to IDLE.
- Priority is MEM over IF. The RESP eligibility rule forces alternation under contention, so neither requester starves.
- Requester contract:
  - addr, we and wdata stay stable while req=1.
  - req stays high until ack.
  - req may be deasserted or re-presented in the cycle after ack.
  - Any violation is a bench assertion failure.
- Reset values: state IDLE, owner IF, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, every ack=0, every err=0.
- Reset mid-operation: the transaction is abandoned and no ack is issued. ram_en drops asynchronously, so a write in ISSUE does not commit.

## Timing
- A request seen in cycle N with the port idle issues in N+1 and is acked in N+2.
- Under contention, the losing requester is issued in N+3 and acked in N+4.
- Peak throughput is one access every 2 cycles.
- ack is a decode of state and owner; it never goes high for two consecutive cycles to the same requester.

## Configuration
- MEM_ARB_ALIGN_CHK_EN defined:
  - An address with addr[1:0]!=0 still passes through ISSUE and RESP timing, but ram_en stays 0.
  - RESP asserts ack with err=1 and rdata=0.
- MEM_ARB_ALIGN_CHK_EN undefined: err is tied 0 and every address is forwarded unchanged.

## Structure
- Package mem_arb_pkg holds the state typedef (IDLE/ISSUE/RESP), the owner typedef (OWN_IF/OWN_MEM), and the ADDR_W/DATA_W defaults.
- No sub-module; the FSM, command registers and response decode live in one module.

## Test plan
- Reset: assert rst mid-run, then release. Throughout: ram_en=0, ram_addr=0, if_ack=0, mem_ack=0, busy=0, state IDLE.
- IF read: RAM word 0x010 = 0xDEADBEEF; if_req in cycle 0 with if_addr=0x010. Cycle 1: ram_en=1, ram_addr=0x010. Cycle 2: if_ack=1, if_rdata=0xDEADBEEF. Cycle 3: busy=0.
- Contention:
  - Stimulus: in cycle 0, if_req with addr 0x020 and mem_req write 0x12345678 to 0x100.
  - Cycle 1: ram_we=1, ram_addr=0x100.
  - Cycle 2: mem_ack=1.
  - Cycle 3: ram_addr=0x020, ram_we=0.
  - Cycle 4: if_ack=1.
  - A later read of 0x100 returns 0x12345678.
- Alternation: both requesters held high and re-requesting continuously for 20 cycles. Acks alternate MEM, IF, MEM, IF, one every 2 cycles; if_stall is never high for more than 4 cycles.
- Misaligned access: MEM write to 0x102.
  - With MEM_ARB_ALIGN_CHK_EN: ram_en stays 0, mem_ack=1 with mem_err=1 in cycle 2, and memory is unchanged.
  - Without the macro: ram_addr=0x102 and mem_err=0.
- Reset during ISSUE of a MEM write to 0x200: ram_en falls immediately, mem_ack never pulses, and word 0x200 keeps its old value.
